// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS register file and its debug
// read-out engine (reg_dump).
//   MIPS_REG_ADDR_W  register address width
//   MIPS_REG_DATA_W  register data width
//   MIPS_NUM_REGS    number of architectural registers
//   dump_state_e     reg_dump sequencer states (CSUM is reached only when
//                    REG_DUMP_CHECKSUM_EN is defined)
package mips_pkg;

  localparam int MIPS_REG_ADDR_W = 5;
  localparam int MIPS_REG_DATA_W = 32;
  localparam int MIPS_NUM_REGS   = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    CSUM  = 3'd4
  } dump_state_e;

endpackage

// File: rtl/reg_dump.sv
// reg_dump: debug read-out engine for the MIPS register file.
// On a start pulse it walks the register file's second read port through
// addresses 0..NUM_REGS-1, captures each registered read result and emits it,
// tagged with its address, on a valid/ready stream.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle dump request, ignored while busy (and during done)
//   busy       read port owned by this block (core muxes rd_addr on busy)
//   done       one-cycle pulse one edge after the final stream handshake
//   rd_addr    registered read address to the register file
//   rd_data    register file read data, one edge of latency after rd_addr
//   out_valid  stream word valid (registered, independent of out_ready)
//   out_ready  downstream accept
//   out_data   register value (or checksum word)
//   out_addr   address of out_data (0 for the checksum word)
//   out_last   final word of the dump
//
// Build option: define REG_DUMP_CHECKSUM_EN to append one extra word holding
// the XOR of all captured register values (out_addr = 0, out_last = 1).
module reg_dump
  import mips_pkg::*;
#(
  parameter int NUM_REGS = MIPS_NUM_REGS,
  parameter int ADDR_W   = MIPS_REG_ADDR_W,
  parameter int DATA_W   = MIPS_REG_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state;
  logic [ADDR_W-1:0] idx;
  // Set by the final handshake; busy is held for one more edge, which then
  // raises done. This gives the one-edge gap between last handshake and done.
  logic              finishing;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // The address register is the index itself, so rd_addr is glitch-free.
  assign rd_addr = idx;

  // NOTE: every state bit lives in this one clocked block and uses
  // non-blocking assignments, so all reads see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      finishing <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      // NOTE: done defaults low here so it can only ever be a single-cycle pulse.
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (finishing) begin
            finishing <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (start && !done) begin
            // A start coinciding with the done pulse is dropped.
            state <= ISSUE;
            idx   <= '0;
            busy  <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end

        // The register file samples rd_addr on this edge.
        ISSUE: state <= WAIT;

        WAIT: begin
          state     <= SEND;
          out_valid <= 1'b1;
          out_data  <= rd_data;
          out_addr  <= idx;
`ifdef REG_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
          csum      <= csum ^ rd_data;
`else
          out_last  <= (idx == LAST_IDX);
`endif
        end

        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx != LAST_IDX) begin
              idx   <= idx + 1'b1;
              state <= ISSUE;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              state     <= CSUM;
              out_valid <= 1'b1;
              out_data  <= csum;
              out_addr  <= '0;
              out_last  <= 1'b1;
`else
              state     <= IDLE;
              finishing <= 1'b1;
`endif
            end
          end
        end

`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
            finishing <= 1'b1;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: self-checking bench for reg_dump with a behavioural register
// file (one-edge read latency, write port) and a table of dump scenarios.
// Expected words come from the bench's own copy of the register contents;
// expected done time is the no-stall latency plus the stall cycles the bench
// itself caused by holding out_ready low while out_valid was high.
module tb_reg_dump;
  import mips_pkg::*;

  localparam int N  = MIPS_NUM_REGS;
  localparam int AW = MIPS_REG_ADDR_W;
  localparam int DW = MIPS_REG_DATA_W;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;

  reg_dump dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: registered read, synchronous write.
  logic [DW-1:0] mem   [N];
  logic [DW-1:0] model [N];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // preload: 0 -> 0x1000_0000+k, 1 -> k, 2 -> random
  task automatic preload(input int mode);
    for (int k = 0; k < N; k++) begin
      logic [DW-1:0] v;
      case (mode)
        0:       v = 32'h1000_0000 + k;
        1:       v = k;
        default: v = $urandom;
      endcase
      mem[k]   = v;
      model[k] = v;
    end
  endtask

  typedef struct {
    int preload;     // preload mode
    int ready_mode;  // 0 always 1, 1 toggle, 2 random
    int restart_at;  // cycle offset of a stray start, -1 none
    int write_at;    // cycle offset of reg 20 write, -1 none
    int exp_words;   // words in the stream
    int exp_done;    // done cycle offset with no stalls
  } vec_t;

  vec_t vecs[10];

  task automatic run_dump(input vec_t v, input int id);
    logic [DW-1:0] gd[$];
    logic [AW-1:0] ga[$];
    logic          gl[$];
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    logic          pl;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] x;
    int stalls = 0, done_n = -1, first_valid = -1, stable_bad = 0, busy_bad = 0;
    string tag;
    tag = $sformatf("v%0d", id);

    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_rdaddr_after_start"}, rd_addr, 0);

    for (int n = 0; n < 400; n++) begin
      if (done) begin
        done_n = n;
        break;
      end
      if (!busy) busy_bad++;
      if (prev_stall && (out_data !== pd || out_addr !== pa || out_last !== pl || out_valid !== 1'b1))
        stable_bad++;
      if (out_valid && first_valid < 0) first_valid = n;
      case (v.ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start = (n == v.restart_at);
      wr_en = (n == v.write_at);
      wr_addr = AW'(20);
      wr_data = 32'hDEAD_BEEF;
      if (wr_en) model[20] = 32'hDEAD_BEEF;
      if (out_valid) begin
        if (out_ready) begin
          gd.push_back(out_data);
          ga.push_back(out_addr);
          gl.push_back(out_last);
        end else begin
          stalls++;
        end
        prev_stall = !out_ready;
        pd = out_data;
        pa = out_addr;
        pl = out_last;
      end else begin
        prev_stall = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    wr_en = 1'b0;

    check({tag, "_done_cycle"}, done_n, v.exp_done + stalls);
    check({tag, "_busy_low_at_done"}, busy, 0);
    check({tag, "_first_valid"}, first_valid, 2);
    check({tag, "_busy_held"}, busy_bad, 0);
    check({tag, "_stall_stable"}, stable_bad, 0);
    check({tag, "_word_count"}, gd.size(), v.exp_words);

    x = '0;
    for (int k = 0; k < N; k++) begin
      x ^= model[k];
      if (k < gd.size()) begin
        check($sformatf("%s_data%0d", tag, k), gd[k], model[k]);
        check($sformatf("%s_addrlast%0d", tag, k), {ga[k], gl[k]},
              {AW'(k), 1'((CS == 0) && (k == N - 1))});
      end
    end
    if (CS != 0 && gd.size() > N) begin
      check({tag, "_csum_data"}, gd[N], x);
      check({tag, "_csum_addrlast"}, {ga[N], gl[N]}, {AW'(0), 1'b1});
    end

    // done is a single pulse and no second dump was started
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_after"}, {busy, out_valid}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int hit;
    int bad;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    vecs[0] = '{0, 0, -1, -1, N + CS, 97 + CS};
    vecs[1] = '{0, 1, -1, -1, N + CS, 97 + CS};
    vecs[2] = '{0, 0, 10, -1, N + CS, 97 + CS};
    vecs[3] = '{1, 0, -1, -1, N + CS, 97 + CS};
    vecs[4] = '{0, 0, -1,  4, N + CS, 97 + CS};
    vecs[5] = '{2, 2, -1, -1, N + CS, 97 + CS};
    vecs[6] = '{2, 2, -1, -1, N + CS, 97 + CS};
    vecs[7] = '{2, 1, -1, -1, N + CS, 97 + CS};
    vecs[8] = '{2, 2, 20,  4, N + CS, 97 + CS};
    vecs[9] = '{2, 0, -1, -1, N + CS, 97 + CS};

    preload(0);
    tick();
    tick();
    check("reset_outputs", {busy, done, out_valid, out_last, rd_addr, out_addr, out_data},
          '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      preload(vecs[i].preload);
      run_dump(vecs[i], i);
    end

    // start during the done cycle is ignored; the next one is accepted
    preload(0);
    run_dump(vecs[0], 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_next_accepted", {busy, rd_addr}, {1'b1, AW'(0)});
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // start in the done cycle itself
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 0;
    for (int n = 0; n < 200 && !done; n++) tick();
    check("done_reached", done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_ignored", busy, 0);

    // reset while word 7 is valid and stalled
    preload(0);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 0;
    for (int n = 0; n < 100; n++) begin
      if (out_valid && out_addr == AW'(7)) begin
        hit = 1;
        break;
      end
      tick();
    end
    out_ready = 1'b0;
    check("reached_word7", hit, 1);
    tick();
    tick();
    check("word7_stalled", {out_valid, out_addr}, {1'b1, AW'(7)});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, out_valid, out_last, rd_addr, out_addr, out_data},
          '0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (out_valid || busy || done) bad++;
    end
    check("quiet_after_reset", bad, 0);
    run_dump(vecs[0], 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
